// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: scheduler control encodings, sequencer states, AES-128 round count.
package aes_pkg;

    localparam int AES128_ROUNDS = 10;

    localparam logic [1:0] KS_HOLD = 2'b00;
    localparam logic [1:0] KS_LOAD = 2'b01;
    localparam logic [1:0] KS_FWD  = 2'b10;
    localparam logic [1:0] KS_REV  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_PREEXP  = 3'd2,
        ST_PRESENT = 3'd3,
        ST_STEP    = 3'd4,
        ST_DONE    = 3'd5
    } ks_state_e;

endpackage

// File: rtl/AES_key_schedular.sv
// AES-128 round-key register: hold, load, one forward or one reverse expansion step per cycle.
// round_number selects the Rcon; a reverse step from round r to r-1 uses Rcon[r].
module AES_key_schedular
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic [1:0]   control_signal,
    input  logic [3:0]   round_number,
    input  logic [127:0] load_key_in,
    output logic [127:0] key_out
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            4'd11:   return 8'h6c;
            4'd12:   return 8'hd8;
            4'd13:   return 8'hab;
            4'd14:   return 8'h4d;
            default: return 8'h00;
        endcase
    endfunction

    // SubWord(RotWord(w)) ^ Rcon
    function automatic logic [31:0] g_word(input logic [31:0] w, input logic [3:0] rnd);
        return {SBOX[w[23:16]] ^ rcon(rnd), SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
    endfunction

    logic [127:0] r_key;
    logic [31:0]  w_f0, w_f1, w_f2, w_f3;
    logic [31:0]  w_r0, w_r1, w_r2, w_r3;

    always_comb begin
        w_f0 = r_key[127:96] ^ g_word(r_key[31:0], round_number);
        w_f1 = r_key[95:64] ^ w_f0;
        w_f2 = r_key[63:32] ^ w_f1;
        w_f3 = r_key[31:0]  ^ w_f2;
        w_r3 = r_key[31:0]  ^ r_key[63:32];
        w_r2 = r_key[63:32] ^ r_key[95:64];
        w_r1 = r_key[95:64] ^ r_key[127:96];
        w_r0 = r_key[127:96] ^ g_word(w_r3, round_number);
    end

    always_ff @(posedge clk) begin
        case (control_signal)
            KS_LOAD: r_key <= load_key_in;
            KS_FWD:  r_key <= {w_f0, w_f1, w_f2, w_f3};
            KS_REV:  r_key <= {w_r0, w_r1, w_r2, w_r3};
            default: r_key <= r_key;
        endcase
    end

    assign key_out = r_key;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Sequences AES_key_schedular through load/forward/reverse so round keys appear in cipher order.
// Every output is a register; key_ack and start only influence the next state.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         decrypt,
    input  logic [127:0] key_in,
    output logic [127:0] sched_key_out,
    output logic [1:0]   sched_ctrl,
    output logic [3:0]   sched_round,
    output logic         key_valid,
    input  logic         key_ack,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    ks_state_e    r_state;
    logic         r_dec;
    logic [127:0] r_key;
    logic [1:0]   r_sched_ctrl;
    logic [3:0]   r_sched_round;
    logic         r_key_valid;
    logic [3:0]   r_round_idx;
    logic         r_busy;
    logic         r_done;
    logic         w_final;

    // Decrypt finishes at round 0, encrypt at the last round.
    assign w_final = r_dec ? (r_round_idx == 4'd0) : (r_round_idx == LAST_ROUND);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_dec         <= 1'b0;
            r_key         <= '0;
            r_sched_ctrl  <= KS_HOLD;
            r_sched_round <= 4'd0;
            r_key_valid   <= 1'b0;
            r_round_idx   <= 4'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_LOAD;
                        r_dec        <= decrypt;
                        r_key        <= key_in;
                        r_sched_ctrl <= KS_LOAD;
                        r_round_idx  <= 4'd0;
                        r_busy       <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (r_dec) begin
                        r_state       <= ST_PREEXP;
                        r_sched_ctrl  <= KS_FWD;
                        r_sched_round <= 4'd1;
                    end else begin
                        r_state      <= ST_PRESENT;
                        r_sched_ctrl <= KS_HOLD;
                        r_key_valid  <= 1'b1;
                    end
                end
                ST_PREEXP: begin
                    if (r_sched_round == LAST_ROUND) begin
                        r_state       <= ST_PRESENT;
                        r_sched_ctrl  <= KS_HOLD;
                        r_sched_round <= 4'd0;
                        r_round_idx   <= LAST_ROUND;
                        r_key_valid   <= 1'b1;
                    end else begin
                        r_sched_round <= r_sched_round + 4'd1;
                    end
                end
                ST_PRESENT: begin
                    if (key_ack) begin
                        r_key_valid <= 1'b0;
                        if (w_final) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_STEP;
                            if (r_dec) begin
                                r_sched_ctrl  <= KS_REV;
                                r_sched_round <= r_round_idx;
                            end else begin
                                r_sched_ctrl  <= KS_FWD;
                                r_sched_round <= r_round_idx + 4'd1;
                            end
                        end
                    end
                end
                ST_STEP: begin
                    r_state       <= ST_PRESENT;
                    r_sched_ctrl  <= KS_HOLD;
                    r_sched_round <= 4'd0;
                    r_key_valid   <= 1'b1;
                    r_round_idx   <= r_dec ? (r_round_idx - 4'd1) : (r_round_idx + 4'd1);
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_sched_ctrl <= KS_HOLD;
                    r_key_valid  <= 1'b0;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

    assign sched_key_out = r_key;
    assign sched_ctrl    = r_sched_ctrl;
    assign sched_round   = r_sched_round;
    assign key_valid     = r_key_valid;
    assign round_idx     = r_round_idx;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
Sequencer that drives the AES-128 key scheduler (AES_key_schedular) through its hold, load, forward and reverse operations.
- Encryption: loads the cipher key and steps forward, presenting round keys 0..NUM_ROUNDS.
- Decryption: loads the key, silently pre-expands to round NUM_ROUNDS, then steps in reverse down to round 0.
- Sits between the cipher round controller (consumer, ready/ack handshake) and the scheduler's control_signal, round_number and load_key_in inputs.

Parameters:
NUM_ROUNDS, 10, last round index; legal 1..14; 4-bit round fields.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new schedule; accepted only in IDLE
decrypt  input  1  sampled with start; 0 = forward order, 1 = reverse order
key_in  input  128  cipher key, captured on start acceptance
sched_key_out  output  128  captured key; drives scheduler load_key_in
sched_ctrl  output  2  drives scheduler control_signal (00 hold, 01 load, 10 forward, 11 reverse)
sched_round  output  4  drives scheduler round_number (Rcon index)
key_valid  output  1  scheduler register holds round key round_idx
key_ack  input  1  consumer has used the current key; meaningful only while key_valid=1
round_idx  output  4  round index of the key currently in the scheduler register
busy  output  1  high in every state except IDLE
done  output  1  single-cycle pulse after the final key is acked

Behaviour:
- Reset is synchronous, active-high: clk and rst only. Reset values: state=IDLE, sched_ctrl=00, sched_round=0, key_valid=0, round_idx=0, busy=0, done=0, sched_key_out=0.
- States: IDLE, LOAD, PREEXP, PRESENT, STEP, DONE.
- Outputs are decoded from registered state and counters only; no combinational path from key_ack or start to any output.
- IDLE: sched_ctrl=00.
  - start=1: latch key_in and decrypt, go to LOAD.
- LOAD (1 cycle): sched_ctrl=01, round_idx=0.
  - Encrypt: go to PRESENT.
  - Decrypt: go to PREEXP with counter=0.
- PREEXP (NUM_ROUNDS cycles):
  - sched_ctrl=10, sched_round=counter+1; counter increments each cycle.
  - After the cycle with sched_round=NUM_ROUNDS: round_idx=NUM_ROUNDS, go to PRESENT.
  - key_valid stays 0 throughout.
- PRESENT: sched_ctrl=00, key_valid=1; waits indefinitely.
  - key_ack=1 and the key is final (round_idx=NUM_ROUNDS for encrypt, 0 for decrypt): go to DONE.
  - key_ack=1 otherwise: go to STEP.
- STEP (1 cycle): key_valid=0.
  - Encrypt: sched_ctrl=10, sched_round=round_idx+1; round_idx increments.
  - Decrypt: sched_ctrl=11, sched_round=round_idx (current round's Rcon); round_idx decrements.
  - Then go to PRESENT.
- DONE (1 cycle): done=1, sched_ctrl=00, go to IDLE. busy falls the cycle after DONE.
- sched_round=0 in every state other than PREEXP and STEP.
- Latency, start accepted at cycle t:
  - Encrypt: LOAD at t+1, first key_valid at t+2.
  - Decrypt: LOAD at t+1, PREEXP t+2..t+1+NUM_ROUNDS, first key_valid (round NUM_ROUNDS) at t+2+NUM_ROUNDS.
  - Ack at cycle a: next key_valid at a+2.
  - Done pulse: 1 cycle after the final ack.
- Boundaries:
  - start while busy: ignored; latched key and mode unchanged.
  - start and rst in the same cycle: reset wins.
  - key_ack while key_valid=0: ignored.
  - rst mid-schedule: returns to IDLE next cycle, sched_ctrl=00. The scheduler register contents are don't-care afterwards; the next schedule reloads them.
  - start in the DONE cycle: ignored. start is accepted in IDLE only, so back-to-back schedules have a minimum 1-cycle gap.
  - round_idx never leaves 0..NUM_ROUNDS.

Decomposition:
- Shared package aes_pkg:
  - KS_HOLD=2'b00, KS_LOAD=2'b01, KS_FWD=2'b10, KS_REV=2'b11.
  - Key-sched FSM state typedef.
  - AES128_ROUNDS=10.
- No sub-module: a single FSM plus a 4-bit round counter and the 128-bit key latch.
- The bench instantiates the controller together with AES_key_schedular.

Test Plan:
- Encrypt, key 000102030405060708090a0b0c0d0e0f, immediate ack:
  - Round 0 key = 000102030405060708090a0b0c0d0e0f.
  - Round 1 key = d6aa74fdd2af72fadaa678f1d6ab76fe.
  - Round 10 key = 13111d7fe3944a17f307a78b4d2b30c5.
  - done 1 cycle after the 11th ack; 11 valid windows, each 2 cycles apart.
- Decrypt, same key:
  - First key_valid at t+12 with round_idx=10 and key 13111d7f...30c5.
  - Keys then descend to round 0 = 000102...0f.
  - PREEXP sched_round sequence is 1..10.
- Consumer stalls ack 5 cycles on round 3: key_valid held, sched_ctrl=00, scheduler register unchanged throughout.
- start pulsed mid-encrypt with a different key: ignored; remaining keys match the original schedule.
- rst asserted during decrypt PREEXP: next cycle state=IDLE, busy=0, key_valid=0. A fresh encrypt start then yields the correct round 0 key at t+2.
- Spurious key_ack during LOAD/PREEXP/STEP: no effect; round_idx sequence and valid count unchanged.
